// File: rtl/branch_predictor_ctrl_if.sv
// Fetch/execute-side signal bundle for the branch predictor controller.
// The pipeline drives through the master modport; the predictor sits on the slave modport.
interface branch_predictor_ctrl_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic [XLEN-1:0]      pc_f_i;
    logic [XLEN-1:0]      pc_e_i;
    logic                 branch_e_i;
    logic                 stall_e_i;
    logic                 pc_src_res_e_i;
    logic                 pc_src_pred_e_i;
    logic                 clear_i;
    logic                 pc_src_pred_f_o;
    logic                 mispredict_e_o;
    logic                 busy_o;
    logic [CNT_WIDTH-1:0] branch_cnt_o;
    logic [CNT_WIDTH-1:0] mispredict_cnt_o;

    modport master (
        output pc_f_i, pc_e_i, branch_e_i, stall_e_i, pc_src_res_e_i, pc_src_pred_e_i, clear_i,
        input  pc_src_pred_f_o, mispredict_e_o, busy_o, branch_cnt_o, mispredict_cnt_o
    );

    modport slave (
        input  pc_f_i, pc_e_i, branch_e_i, stall_e_i, pc_src_res_e_i, pc_src_pred_e_i, clear_i,
        output pc_src_pred_f_o, mispredict_e_o, busy_o, branch_cnt_o, mispredict_cnt_o
    );
endinterface

// File: rtl/branch_predictor_ctrl.sv
// Table of 2-bit saturating branch predictors indexed by PC: fetch-side prediction,
// execute-side training, misprediction statistics and a one-entry-per-cycle clear sweep.
module branch_predictor_ctrl #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IDX_BITS  = 6,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic                    clk_i,
    input logic                    reset_i,
    branch_predictor_ctrl_if.slave bus
);
    localparam int unsigned Entries = 2 ** IDX_BITS;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    localparam logic [1:0] CntSu = 2'b00;
    localparam logic [1:0] CntWu = 2'b01;
    localparam logic [1:0] CntSt = 2'b11;

    logic [0:0]           state_q;
    logic [IDX_BITS-1:0]  ptr_q;
    logic [1:0]           table_q [Entries];
    logic [CNT_WIDTH-1:0] branch_cnt_q;
    logic [CNT_WIDTH-1:0] mispredict_cnt_q;

    logic [IDX_BITS-1:0] idx_f;
    logic [IDX_BITS-1:0] idx_e;
    logic [1:0]          entry_e;
    logic [1:0]          entry_upd;
    logic                busy;
    logic                resolve;
    logic                upd;
    logic                mispredict;

    assign idx_f      = bus.pc_f_i[IDX_BITS+1:2];
    assign idx_e      = bus.pc_e_i[IDX_BITS+1:2];
    assign busy       = (state_q == StClear);
    assign resolve    = bus.branch_e_i & ~bus.stall_e_i;
    assign upd        = (state_q == StIdle) & resolve;
    assign mispredict = bus.branch_e_i & (bus.pc_src_res_e_i != bus.pc_src_pred_e_i);

    // Only the index bits of each PC select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pc_f_i[XLEN-1:IDX_BITS+2], bus.pc_f_i[1:0],
                              bus.pc_e_i[XLEN-1:IDX_BITS+2], bus.pc_e_i[1:0]};

    always_comb begin
        entry_e   = table_q[idx_e];
        entry_upd = entry_e;
        if (bus.pc_src_res_e_i) begin
            if (entry_e != CntSt) entry_upd = entry_e + 2'd1;
        end else begin
            if (entry_e != CntSu) entry_upd = entry_e - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            for (int i = 0; i < Entries; i++) table_q[i] <= CntWu;
        end else if (state_q == StIdle) begin
            // A same-cycle update lands first; the sweep will later overwrite it.
            if (upd) table_q[idx_e] <= entry_upd;
            if (bus.clear_i) begin
                state_q <= StClear;
                ptr_q   <= '0;
            end
        end else begin
            table_q[ptr_q] <= CntWu;
            ptr_q          <= ptr_q + 1'b1;
            if (ptr_q == '1) state_q <= StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (resolve) begin
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (mispredict && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
            end
        end
    end

    assign bus.pc_src_pred_f_o  = busy ? 1'b0 : table_q[idx_f][1];
    assign bus.mispredict_e_o   = mispredict;
    assign bus.busy_o           = busy;
    assign bus.branch_cnt_o     = branch_cnt_q;
    assign bus.mispredict_cnt_o = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Self-checking bench: two DUTs (16-bit and 4-bit statistics) driven in lockstep and
// compared against a behavioural predictor-table model.
module tb_branch_predictor_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f, pc_e;
    logic        branch, stall, res, pred_e, clear;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int tbl [64];
    bit m_busy;
    int m_ptr;
    int bcnt16, mcnt16, bcnt4, mcnt4;

    branch_predictor_ctrl_if #(.XLEN(32), .CNT_WIDTH(16)) bus16 ();
    branch_predictor_ctrl_if #(.XLEN(32), .CNT_WIDTH(4))  bus4 ();

    assign bus16.pc_f_i = pc_f;          assign bus4.pc_f_i = pc_f;
    assign bus16.pc_e_i = pc_e;          assign bus4.pc_e_i = pc_e;
    assign bus16.branch_e_i = branch;    assign bus4.branch_e_i = branch;
    assign bus16.stall_e_i = stall;      assign bus4.stall_e_i = stall;
    assign bus16.pc_src_res_e_i = res;   assign bus4.pc_src_res_e_i = res;
    assign bus16.pc_src_pred_e_i = pred_e; assign bus4.pc_src_pred_e_i = pred_e;
    assign bus16.clear_i = clear;        assign bus4.clear_i = clear;

    branch_predictor_ctrl #(.XLEN(32), .IDX_BITS(6), .CNT_WIDTH(16)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus16.slave)
    );

    branch_predictor_ctrl #(.XLEN(32), .IDX_BITS(6), .CNT_WIDTH(4)) dut4 (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus4.slave)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic bit exp_pred();
        return m_busy ? 1'b0 : (tbl[idx_of(pc_f)] >= 2);
    endfunction

    function automatic bit exp_mis();
        return branch && (res != pred_e);
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Advance the model by one edge using the inputs currently applied, then step the clock.
    task automatic tick();
        int  ie;
        bit  cnt;
        bit  mis;
        ie  = idx_of(pc_e);
        cnt = branch && !stall;
        mis = exp_mis();
        if (reset) begin
            foreach (tbl[i]) tbl[i] = 1;
            m_busy = 0; m_ptr = 0;
            bcnt16 = 0; mcnt16 = 0; bcnt4 = 0; mcnt4 = 0;
        end else begin
            if (m_busy) begin
                tbl[m_ptr] = 1;
                m_ptr++;
                if (m_ptr == 64) m_busy = 0;
            end else begin
                if (cnt) tbl[ie] = res ? ((tbl[ie] == 3) ? 3 : tbl[ie] + 1)
                                       : ((tbl[ie] == 0) ? 0 : tbl[ie] - 1);
                if (clear) begin m_busy = 1; m_ptr = 0; end
            end
            if (cnt) begin
                bcnt16 = sat_inc(bcnt16, 65535);
                bcnt4  = sat_inc(bcnt4, 15);
                if (mis) begin
                    mcnt16 = sat_inc(mcnt16, 65535);
                    mcnt4  = sat_inc(mcnt4, 15);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; branch = 0; stall = 0; res = 0; pred_e = 0; clear = 0;
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        reset = 1;
        repeat (cycles) tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset(2);
        for (int i = 0; i < 64; i++) begin
            pc_f = 32'(i * 4);
            #1;
            total++;
            if (bus16.pc_src_pred_f_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_pred pc=%h got=%b want=0", pc_f, bus16.pc_src_pred_f_o);
            end
        end
        total++;
        if (bus16.busy_o !== 1'b0 || bus16.branch_cnt_o !== 16'd0 ||
            bus16.mispredict_cnt_o !== 16'd0) begin
            bad++;
            $display("FAIL reset_state got busy=%b bcnt=%0d mcnt=%0d want 0/0/0",
                     bus16.busy_o, bus16.branch_cnt_o, bus16.mispredict_cnt_o);
        end
    endtask

    task automatic test_train();
        logic [8:0] want_seq;
        want_seq = 9'b000111110;  // bit k = expected prediction at sample k
        do_reset(1);
        pc_f = 32'h40; pc_e = 32'h40; branch = 1;
        for (int k = 0; k < 9; k++) begin
            #1;
            total++;
            if (bus16.pc_src_pred_f_o !== want_seq[k] || bus16.pc_src_pred_f_o !== exp_pred()) begin
                bad++;
                $display("FAIL train_seq step=%0d got=%b want=%b", k, bus16.pc_src_pred_f_o,
                         want_seq[k]);
            end
            if (k < 8) begin
                res = (k < 4); pred_e = bus16.pc_src_pred_f_o;
                tick();
            end
        end
        idle_inputs();
    endtask

    task automatic test_alias();
        logic [31:0] pcs [3];
        pcs[0] = 32'h40; pcs[1] = 32'h140; pcs[2] = 32'h44;
        do_reset(1);
        branch = 1; res = 1;
        pc_e = 32'h40;  tick();
        pc_e = 32'h140; tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            pc_f = pcs[k];
            #1;
            total++;
            if (bus16.pc_src_pred_f_o !== exp_pred()) begin
                bad++;
                $display("FAIL alias_pred pc=%h got=%b want=%b", pc_f, bus16.pc_src_pred_f_o,
                         exp_pred());
            end
        end
    endtask

    task automatic test_stall();
        int b0, m0;
        do_reset(1);
        b0 = bcnt16; m0 = mcnt16;
        pc_e = 32'h80; pc_f = 32'h80;
        branch = 1; stall = 1; res = 1; pred_e = 0;
        repeat (3) begin
            #1;
            total++;
            if (bus16.mispredict_e_o !== 1'b1) begin
                bad++;
                $display("FAIL stall_mispredict got=%b want=1", bus16.mispredict_e_o);
            end
            tick();
        end
        total++;
        if (bus16.branch_cnt_o !== 16'(b0) || bus16.mispredict_cnt_o !== 16'(m0) ||
            bus16.pc_src_pred_f_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_nochange got bcnt=%0d mcnt=%0d pred=%b want %0d/%0d/0",
                     bus16.branch_cnt_o, bus16.mispredict_cnt_o, bus16.pc_src_pred_f_o, b0, m0);
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int n;
        do_reset(1);
        branch = 1; res = 1; pc_e = 32'h14;
        repeat (3) tick();
        pc_e = 32'h24; clear = 1;
        tick();
        clear = 0; branch = 0;
        pc_f = 32'h14;
        n = 0;
        while (bus16.busy_o === 1'b1 && n < 200) begin
            clear = (n == 30);
            // Updates offered during the sweep must be dropped.
            branch = 1; res = 1; pc_e = 32'h100;
            #1;
            total++;
            if (bus16.pc_src_pred_f_o !== 1'b0 || bus16.busy_o !== m_busy) begin
                bad++;
                $display("FAIL clear_forced n=%0d got pred=%b busy=%b want 0/%b", n,
                         bus16.pc_src_pred_f_o, bus16.busy_o, m_busy);
            end
            tick();
            n++;
        end
        idle_inputs();
        total++;
        if (n != 64) begin
            bad++;
            $display("FAIL clear_busy_len got=%0d want=64", n);
        end
        for (int i = 0; i < 64; i++) begin
            pc_f = 32'(i * 4);
            #1;
            total++;
            if (bus16.pc_src_pred_f_o !== 1'b0 || tbl[i] != 1) begin
                bad++;
                $display("FAIL clear_after idx=%0d got=%b want=0", i, bus16.pc_src_pred_f_o);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            pc_f   = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 7) << 2);
            pc_e   = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 7) << 2);
            branch = ($urandom_range(0, 3) != 0);
            stall  = ($urandom_range(0, 4) == 0);
            res    = $urandom_range(0, 1) == 1;
            pred_e = $urandom_range(0, 1) == 1;
            clear  = ($urandom_range(0, 59) == 0);
            #1;
            total++;
            if (bus16.pc_src_pred_f_o !== exp_pred() || bus16.mispredict_e_o !== exp_mis() ||
                bus16.busy_o !== m_busy || bus16.branch_cnt_o !== 16'(bcnt16) ||
                bus16.mispredict_cnt_o !== 16'(mcnt16) || bus4.branch_cnt_o !== 4'(bcnt4) ||
                bus4.mispredict_cnt_o !== 4'(mcnt4) || bus4.pc_src_pred_f_o !== exp_pred()) begin
                bad++;
                $display("FAIL random c=%0d got pred=%b mis=%b busy=%b b=%0d m=%0d b4=%0d m4=%0d want %b/%b/%b/%0d/%0d/%0d/%0d",
                         c, bus16.pc_src_pred_f_o, bus16.mispredict_e_o, bus16.busy_o,
                         bus16.branch_cnt_o, bus16.mispredict_cnt_o, bus4.branch_cnt_o,
                         bus4.mispredict_cnt_o, exp_pred(), exp_mis(), m_busy, bcnt16, mcnt16,
                         bcnt4, mcnt4);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_sat_and_reset_mid_sweep();
        do_reset(1);
        pc_e = 32'hA0; branch = 1; res = 1; pred_e = 0;
        repeat (20) tick();
        branch = 0;
        #1;
        total++;
        if (bus4.branch_cnt_o !== 4'd15 || bus4.mispredict_cnt_o !== 4'd15 ||
            bus16.mispredict_cnt_o !== 16'd20) begin
            bad++;
            $display("FAIL sat_counts got b4=%0d m4=%0d m16=%0d want 15/15/20",
                     bus4.branch_cnt_o, bus4.mispredict_cnt_o, bus16.mispredict_cnt_o);
        end
        // idx 40 is now ST and lies beyond where the interrupted sweep reaches.
        clear = 1; tick(); clear = 0;
        repeat (19) tick();
        reset = 1; tick(); reset = 0;
        total++;
        if (bus16.busy_o !== 1'b0 || bus16.branch_cnt_o !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_sweep got busy=%b bcnt=%0d want 0/0", bus16.busy_o,
                     bus16.branch_cnt_o);
        end
        for (int i = 0; i < 64; i++) begin
            pc_f = 32'(i * 4);
            #1;
            total++;
            if (bus16.pc_src_pred_f_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_sweep_pred idx=%0d got=%b want=0", i,
                         bus16.pc_src_pred_f_o);
            end
        end
    endtask

    initial begin
        idle_inputs();
        pc_f = '0; pc_e = '0;
        foreach (tbl[i]) tbl[i] = 1;
        m_busy = 0; m_ptr = 0;
        bcnt16 = 0; mcnt16 = 0; bcnt4 = 0; mcnt4 = 0;
        test_reset();
        test_train();
        test_alias();
        test_stall();
        test_clear();
        test_random();
        test_sat_and_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
